lspc_vram_slot_arbiter: RTL

//  Time-slot arbiter sharing the single 16-bit VRAM port between the video fetch engine and the 68k CPU.

---
 rtl/lspc_vram_slot_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/lspc_vram_slot_arbiter.sv
// LSPC VRAM slot arbiter: shares the single 16-bit VRAM port between video fetch and the 68k,
// one slot per CE_3M strobe, with a starvation guard that forces a CPU grant.
module lspc_vram_slot_arbiter #(
    parameter logic [7:0]  VID_SLOT_MASK = 8'b0011_1111,
    parameter int unsigned VRAM_LAT      = 2,
    parameter int unsigned STARVE_LIMIT  = 16
) (
    input  logic        CLK_24MB,
    input  logic        nRESETP,
    input  logic        CE_3M,
    input  logic [2:0]  PIXEL_PH,
    input  logic        VBLANK,
    input  logic        VID_REQ,
    input  logic [15:0] VID_ADDR,
    output logic        VID_ACK,
    output logic [15:0] VID_RDATA,
    output logic        VID_MISS,
    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [15:0] CPU_ADDR,
    input  logic [15:0] CPU_WDATA,
    output logic        CPU_ACK,
    output logic [15:0] CPU_RDATA,
    output logic [15:0] VRAM_ADDR,
    output logic        VRAM_WE,
    output logic [15:0] VRAM_WDATA,
    input  logic [15:0] VRAM_RDATA
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [2:0]  wait_cnt_r, wait_cnt_s;
    logic [7:0]  starve_cnt_r, starve_cnt_s;
    logic        own_cpu_r, cpu_wr_r;
    logic        vid_ack_r, vid_miss_r, cpu_ack_r, vram_we_r;
    logic [15:0] vid_rdata_r, cpu_rdata_r, vram_addr_r, vram_wdata_r;
    logic        strobe_s, vslot_s, starved_s, grant_vid_s, grant_cpu_s, miss_s, capture_s;

    // Slot decision; a strobe that lands while an access is in flight never grants.
    always_comb begin
        strobe_s    = CE_3M & (state_r == ST_IDLE);
        vslot_s     = VID_SLOT_MASK[PIXEL_PH] & ~VBLANK;
        starved_s   = CPU_REQ & ({24'd0, starve_cnt_r} >= STARVE_LIMIT);
        grant_vid_s = strobe_s & vslot_s & VID_REQ & ~starved_s;
        grant_cpu_s = strobe_s & CPU_REQ & ~grant_vid_s;
        miss_s      = strobe_s & vslot_s & VID_REQ & starved_s;
    end

    // Starvation counter: counts lost strobes of a pending CPU request, saturating.
    always_comb begin
        starve_cnt_s = starve_cnt_r;
        if (!CPU_REQ || grant_cpu_s) begin
            starve_cnt_s = 8'd0;
        end else if (strobe_s && (starve_cnt_r != 8'hFF)) begin
            starve_cnt_s = starve_cnt_r + 8'd1;
        end else begin
            starve_cnt_s = starve_cnt_r;
        end
    end

    // Access sequencer next state; DONE is the cycle the grantee ack is visible.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_vid_s || grant_cpu_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (VRAM_LAT > 32'd1) begin
                    state_s    = ST_WAIT;
                    wait_cnt_s = 3'(VRAM_LAT - 32'd2);
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 3'd0) begin
                    state_s = ST_DONE;
                end else begin
                    wait_cnt_s = wait_cnt_r - 3'd1;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
        capture_s = (state_s == ST_DONE);
    end

    // Control state registers.
    always_ff @(posedge CLK_24MB or negedge nRESETP) begin
        if (!nRESETP) begin
            state_r      <= ST_IDLE;
            wait_cnt_r   <= 3'd0;
            starve_cnt_r <= 8'd0;
        end else begin
            state_r      <= state_s;
            wait_cnt_r   <= wait_cnt_s;
            starve_cnt_r <= starve_cnt_s;
        end
    end

    // Datapath: latch grantee at the strobe, drive VRAM in ISSUE, capture and ack at DONE.
    always_ff @(posedge CLK_24MB or negedge nRESETP) begin
        if (!nRESETP) begin
            own_cpu_r    <= 1'b0;
            cpu_wr_r     <= 1'b0;
            vid_ack_r    <= 1'b0;
            vid_miss_r   <= 1'b0;
            cpu_ack_r    <= 1'b0;
            vram_we_r    <= 1'b0;
            vid_rdata_r  <= 16'd0;
            cpu_rdata_r  <= 16'd0;
            vram_addr_r  <= 16'd0;
            vram_wdata_r <= 16'd0;
        end else begin
            vid_ack_r  <= 1'b0;
            cpu_ack_r  <= 1'b0;
            vram_we_r  <= 1'b0;
            vid_miss_r <= miss_s;
            if (grant_vid_s || grant_cpu_s) begin
                own_cpu_r   <= grant_cpu_s;
                cpu_wr_r    <= grant_cpu_s & CPU_WE;
                vram_we_r   <= grant_cpu_s & CPU_WE;
                vram_addr_r <= grant_cpu_s ? CPU_ADDR : VID_ADDR;
                if (grant_cpu_s) begin
                    vram_wdata_r <= CPU_WDATA;
                end
            end
            if (capture_s) begin
                if (own_cpu_r) begin
                    cpu_ack_r <= 1'b1;
                    if (!cpu_wr_r) begin
                        cpu_rdata_r <= VRAM_RDATA;
                    end
                end else begin
                    vid_ack_r   <= 1'b1;
                    vid_rdata_r <= VRAM_RDATA;
                end
            end
        end
    end

    // Strobes must only arrive while the sequencer is idle.
    always_ff @(posedge CLK_24MB) begin
        if (nRESETP && CE_3M) begin
            assert (state_r == ST_IDLE);
        end
    end

    assign VID_ACK    = vid_ack_r;
    assign VID_RDATA  = vid_rdata_r;
    assign VID_MISS   = vid_miss_r;
    assign CPU_ACK    = cpu_ack_r;
    assign CPU_RDATA  = cpu_rdata_r;
    assign VRAM_ADDR  = vram_addr_r;
    assign VRAM_WE    = vram_we_r;
    assign VRAM_WDATA = vram_wdata_r;

endmodule
